// File: rtl/uvc_payload_gen.sv
// uvc_payload_gen: UVC isochronous payload generator.
// Once per frame interval (SOF_PER_FRAME microframes) turns a 24-bit {Y,U,V}
// pixel stream into UVC payloads (header + YUY2 bytes) for the USB TX FIFO.
// Optional macro UVC_PTS_EN: 12-byte header carrying PTS, SCR/STC and the
// 11-bit frame number; when undefined, 2-byte header and no timestamp logic.
module uvc_payload_gen #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int PAYLOAD_SIZE  = 1024,
  parameter int SOF_PER_FRAME = 104
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic        SOF_I,
  input  logic        FIFO_AFULL_I,
  input  logic        FIFO_EMPTY_I,
  input  logic [23:0] PIX_DATA_I,
  input  logic        PIX_VALID_I,
  output logic        PIX_REQ_O,
  output logic [7:0]  DATA_O,
  output logic        DVAL_O,
  output logic        VS_O,
  output logic        EOF_O
);

`ifdef UVC_PTS_EN
  localparam int         HLEN     = 12;
  localparam logic [7:0] PTS_BITS = 8'h0C;
`else
  localparam int         HLEN     = 2;
  localparam logic [7:0] PTS_BITS = 8'h00;
`endif

  localparam logic [31:0] FRAME_BYTES = 32'(WIDTH * HEIGHT * 2);
  localparam logic [31:0] DPL         = 32'(PAYLOAD_SIZE - HLEN);
  localparam int          SCW         = $clog2(SOF_PER_FRAME);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  logic [1:0]     state;
  logic           sof_d0, sof_d1, sof_rise;
  logic [SCW-1:0] sof_cnt;
  logic [15:0]    byte_idx;
  logic [31:0]    frame_byte;
  logic [1:0]     grp;
  logic           fid;
  logic           hdr_emit, pay_emit, frame_start, last_byte, eof_flag;
  logic [7:0]     hdr_byte, pix_byte;

`ifdef UVC_PTS_EN
  logic [31:0] pts, pts_reg, scr_reg;
  logic [2:0]  sof_1ms;
  logic [10:0] frame_num;
`endif

  // Emit qualifiers, frame start and EOF decision for the current payload
  always_comb begin
    sof_rise    = sof_d0 & ~sof_d1;
    hdr_emit    = (state == S_HEADER) && !FIFO_AFULL_I;
    pay_emit    = (state == S_PAYLOAD) && !FIFO_AFULL_I && PIX_VALID_I;
    PIX_REQ_O   = pay_emit & grp[0];
    frame_start = (state == S_IDLE) && sof_rise && (sof_cnt == '0) && FIFO_EMPTY_I;
    last_byte   = (frame_byte == FRAME_BYTES - 32'd1);
    eof_flag    = ((FRAME_BYTES - frame_byte) <= DPL);
  end

  // Header byte selected by position within the header
  always_comb begin
    hdr_byte = '0;
    case (byte_idx)
      16'd0:   hdr_byte = 8'(HLEN);
      16'd1:   hdr_byte = 8'h80 | PTS_BITS | {6'b0, eof_flag, fid};
`ifdef UVC_PTS_EN
      16'd2:   hdr_byte = pts_reg[7:0];
      16'd3:   hdr_byte = pts_reg[15:8];
      16'd4:   hdr_byte = pts_reg[23:16];
      16'd5:   hdr_byte = pts_reg[31:24];
      16'd6:   hdr_byte = scr_reg[7:0];
      16'd7:   hdr_byte = scr_reg[15:8];
      16'd8:   hdr_byte = scr_reg[23:16];
      16'd9:   hdr_byte = scr_reg[31:24];
      16'd10:  hdr_byte = frame_num[7:0];
      16'd11:  hdr_byte = {5'b0, frame_num[10:8]};
`endif
      default: hdr_byte = '0;
    endcase
  end

  // YUY2 packing: Y0 U Y1 V, second Y taken from the next (show-ahead) pixel
  always_comb begin
    pix_byte = '0;
    case (grp)
      2'd0:    pix_byte = PIX_DATA_I[23:16];
      2'd1:    pix_byte = PIX_DATA_I[15:8];
      2'd2:    pix_byte = PIX_DATA_I[23:16];
      default: pix_byte = PIX_DATA_I[7:0];
    endcase
  end

  // SOF edge detect and position within the frame interval
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sof_d0  <= 1'b0;
      sof_d1  <= 1'b0;
      sof_cnt <= '0;
    end else begin
      sof_d0 <= SOF_I;
      sof_d1 <= sof_d0;
      if (sof_rise) begin
        if (sof_cnt == SCW'(SOF_PER_FRAME - 1)) sof_cnt <= '0;
        else                                    sof_cnt <= sof_cnt + 1'b1;
      end
    end
  end

`ifdef UVC_PTS_EN
  // Timestamp counter, per-frame PTS, per-payload STC and 1 ms frame number
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      pts       <= '0;
      pts_reg   <= '0;
      scr_reg   <= '0;
      sof_1ms   <= '0;
      frame_num <= '0;
    end else begin
      pts <= pts + 32'd1;
      if (frame_start) pts_reg <= pts;
      if (hdr_emit && byte_idx == 16'd0) scr_reg <= pts;
      if (sof_rise) begin
        sof_1ms <= sof_1ms + 3'd1;
        if (sof_1ms == 3'd7) frame_num <= frame_num + 11'd1;
      end
    end
  end
`endif

  // Frame / payload sequencer with registered byte output
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state      <= S_IDLE;
      byte_idx   <= '0;
      frame_byte <= '0;
      grp        <= '0;
      fid        <= 1'b0;
      DATA_O     <= '0;
      DVAL_O     <= 1'b0;
      VS_O       <= 1'b0;
      EOF_O      <= 1'b0;
    end else begin
      DVAL_O <= 1'b0;
      EOF_O  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state      <= S_HEADER;
            byte_idx   <= '0;
            frame_byte <= '0;
            grp        <= '0;
            VS_O       <= 1'b1;
          end
        end
        S_HEADER: begin
          if (hdr_emit) begin
            DATA_O <= hdr_byte;
            DVAL_O <= 1'b1;
            if (byte_idx == 16'(HLEN - 1)) begin
              byte_idx <= '0;
              state    <= S_PAYLOAD;
            end else begin
              byte_idx <= byte_idx + 16'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (pay_emit) begin
            DATA_O     <= pix_byte;
            DVAL_O     <= 1'b1;
            grp        <= grp + 2'd1;
            frame_byte <= frame_byte + 32'd1;
            // Frame end takes priority over a payload boundary on the same byte
            if (last_byte) begin
              EOF_O    <= 1'b1;
              VS_O     <= 1'b0;
              fid      <= ~fid;
              byte_idx <= '0;
              state    <= S_IDLE;
            end else if ({16'b0, byte_idx} == DPL - 32'd1) begin
              byte_idx <= '0;
              state    <= S_HEADER;
            end else begin
              byte_idx <= byte_idx + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uvc_payload_gen.sv
// Scoreboard bench for uvc_payload_gen (4x2 frame, 20-byte payloads).
// Expected streams are queued at stimulus time; a negedge monitor pops and
// compares every DVAL_O byte, stall gap lengths and PIX_REQ_O pulse counts.
module tb_uvc_payload_gen;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int PS  = 20;
  localparam int SPF = 2;
`ifdef UVC_PTS_EN
  localparam int         HLEN = 12;
  localparam logic [7:0] PTSB = 8'h0C;
`else
  localparam int         HLEN = 2;
  localparam logic [7:0] PTSB = 8'h00;
`endif
  localparam int DPL = PS - HLEN;
  localparam int FB  = W * H * 2;

  logic        CLK_I = 1'b0;
  logic        RSTN_I = 1'b0;
  logic        SOF_I = 1'b0;
  logic        FIFO_AFULL_I = 1'b0;
  logic        FIFO_EMPTY_I = 1'b1;
  logic        PIX_VALID_I = 1'b1;
  logic [23:0] PIX_DATA_I;
  logic        PIX_REQ_O;
  logic [7:0]  DATA_O;
  logic        DVAL_O, VS_O, EOF_O;

  uvc_payload_gen #(
    .WIDTH(W), .HEIGHT(H), .PAYLOAD_SIZE(PS), .SOF_PER_FRAME(SPF)
  ) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .SOF_I(SOF_I),
    .FIFO_AFULL_I(FIFO_AFULL_I), .FIFO_EMPTY_I(FIFO_EMPTY_I),
    .PIX_DATA_I(PIX_DATA_I), .PIX_VALID_I(PIX_VALID_I), .PIX_REQ_O(PIX_REQ_O),
    .DATA_O(DATA_O), .DVAL_O(DVAL_O), .VS_O(VS_O), .EOF_O(EOF_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Show-ahead pixel source: pixel n = {0x10+n, 0x80, 0x90}; flushed on reset
  int pidx;
  always @(posedge CLK_I or negedge RSTN_I)
    if (!RSTN_I) pidx <= 0;
    else if (PIX_REQ_O) pidx <= pidx + 1;
  assign PIX_DATA_I = {8'(32'h10 + pidx), 8'h80, 8'h90};

  typedef struct { logic [7:0] d; logic eof; logic chk; } exp_t;
  exp_t exp_q[$];
  int   gap_q[$];
  int   req_q[$];

  int checks = 0, fails = 0;
  int byte_cnt = 0, req_cnt = 0, gap = 0, total = 0;
  bit in_frame = 0, eof_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Queue the expected byte stream of one frame
  task automatic push_frame(input logic fid, input int base, input logic [10:0] fnum);
    int   n = 0;
    exp_t e;
    while (n < FB) begin
      for (int i = 0; i < HLEN; i++) begin
        e.eof = 1'b0;
        e.chk = 1'b1;
        case (i)
          0:       e.d = 8'(HLEN);
          1:       e.d = 8'h80 | PTSB | ((FB - n <= DPL) ? 8'h02 : 8'h00) | {7'b0, fid};
          10:      e.d = fnum[7:0];
          11:      e.d = {5'b0, fnum[10:8]};
          default: begin e.d = 8'h00; e.chk = 1'b0; end
        endcase
        exp_q.push_back(e);
      end
      for (int k = 0; k < DPL && n < FB; k++) begin
        e.chk = 1'b1;
        case (n % 4)
          1:       e.d = 8'h80;
          3:       e.d = 8'h90;
          default: e.d = 8'(32'h10 + base + n / 2);
        endcase
        e.eof = (n == FB - 1);
        exp_q.push_back(e);
        n++;
      end
    end
    req_q.push_back(FB / 2);
    eof_seen = 0;
  endtask

  // Monitor: compares bytes, EOF/VS, stall gaps and pop-strobe qualification
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK_I);
      if (PIX_REQ_O) begin
        check("pix_req_qual", 32'({PIX_VALID_I, FIFO_AFULL_I}), 32'h2);
        req_cnt++;
      end
      if (DVAL_O) begin
        total++;
        if (gap > 0) begin
          if (gap_q.size() == 0) fail_now($sformatf("unexpected_gap len=%0d", gap));
          else check("gap_len", 32'(gap), 32'(gap_q.pop_front()));
          gap = 0;
        end
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_byte got %02h", DATA_O));
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check($sformatf("data[%0d]", byte_cnt), 32'(DATA_O), 32'(e.d));
          check("eof", 32'(EOF_O), 32'(e.eof));
          check("vs", 32'(VS_O), 32'(!e.eof));
        end
        in_frame = 1;
        byte_cnt++;
        if (EOF_O) begin
          if (req_q.size() == 0) fail_now("req_count_unexpected");
          else check("req_count", 32'(req_cnt), 32'(req_q.pop_front()));
          check("gaps_left", 32'(gap_q.size()), 32'd0);
          req_cnt  = 0;
          byte_cnt = 0;
          in_frame = 0;
          eof_seen = 1;
        end
      end else if (in_frame) begin
        gap++;
      end
    end
  end

  task automatic sof();
    @(negedge CLK_I); SOF_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    SOF_I = 1'b0;
    repeat (2) @(negedge CLK_I);
  endtask

  task automatic wait_eof(input string name);
    for (int i = 0; i < 300 && !eof_seen; i++) begin
      @(negedge CLK_I); #1;
    end
    if (!eof_seen) fail_now({name, "_eof_timeout"});
  endtask

  task automatic wait_bytes(input int n, input string name);
    int i = 0;
    while (byte_cnt < n && i < 300) begin
      @(negedge CLK_I); #1;
      i++;
    end
    if (byte_cnt < n) fail_now({name, "_byte_timeout"});
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_data"}, 32'(DATA_O), 32'd0);
    check({name, "_dval"}, 32'(DVAL_O), 32'd0);
    check({name, "_vs"},   32'(VS_O),   32'd0);
    check({name, "_eof"},  32'(EOF_O),  32'd0);
    check({name, "_req"},  32'(PIX_REQ_O), 32'd0);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge CLK_I);
    check_outputs_zero("reset");
    RSTN_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // Frame 0: FID 0, pixels 0..7
    push_frame(1'b0, 0, 11'd0);
    sof();
    wait_eof("f0");

    // Mid-interval SOF: no frame
    t0 = total;
    sof();
    repeat (20) @(negedge CLK_I);
    check("mid_interval_idle", 32'(total), 32'(t0));

    // Frame 1: FID 1 with a 5-cycle AFULL stall and a 3-cycle pixel underrun
    gap_q.push_back(5);
    gap_q.push_back(3);
    push_frame(1'b1, 8, 11'd0);
    sof();
    wait_bytes(4, "f1a");
    FIFO_AFULL_I = 1'b1;
    repeat (5) @(negedge CLK_I);
    FIFO_AFULL_I = 1'b0;
    wait_bytes(14, "f1b");
    PIX_VALID_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    PIX_VALID_I = 1'b1;
    wait_eof("f1");
    sof();
    repeat (20) @(negedge CLK_I);

    // Frame-start SOF with TX FIFO not empty: skipped, FID kept
    FIFO_EMPTY_I = 1'b0;
    t0 = total;
    sof();
    repeat (30) @(negedge CLK_I);
    check("skip_no_bytes", 32'(total), 32'(t0));
    FIFO_EMPTY_I = 1'b1;
    sof();
    repeat (20) @(negedge CLK_I);

    // Frame 2: FID back to 0 after frame 1, pixels 16..23
    push_frame(1'b0, 16, 11'd0);
    sof();
    wait_eof("f2");
    sof();
    repeat (20) @(negedge CLK_I);

    // Frame 3: frame_num now 1; reset asserted mid-payload
    push_frame(1'b1, 24, 11'd1);
    sof();
    wait_bytes(14, "f3");
    #2 RSTN_I = 1'b0;
    #1 check_outputs_zero("async_reset");
    exp_q.delete();
    gap_q.delete();
    req_q.delete();
    in_frame = 0;
    gap      = 0;
    req_cnt  = 0;
    byte_cnt = 0;
    repeat (3) @(negedge CLK_I);
    RSTN_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // Frame 4: restarts with FID 0, pixel source flushed
    push_frame(1'b0, 0, 11'd0);
    sof();
    wait_eof("f4");
    repeat (5) @(negedge CLK_I);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
